// File: rtl/nrisc_ula_seq.sv
// nrisc_ula_seq -- sequential ALU for the NRISC datapath.
//
// Accepts an operation on a start/busy handshake, latches the operands and
// opcode, and produces a registered result and flags with a one-cycle done
// pulse. Single-cycle operations finish one edge after acceptance. Multiply
// and the shift/rotate-by-N family iterate one step per clock.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   ULA_A      operand A
//   ULA_B      operand B (shift amount n = B[SW-1:0] for N-shifts)
//   ULA_ctrl   operation select
//   ULA_start  request, accepted when ULA_busy is low
//   ULA_busy   multi-cycle operation in flight
//   ULA_done   one-cycle pulse when ULA_OUT/ULA_flags update
//   ULA_OUT    registered result, held until the next completion
//   ULA_flags  registered {minus, zero, carry}
module nrisc_ula_seq #(
  parameter int TAM = 16,
  parameter int SW  = $clog2(TAM)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  input  logic           ULA_start,
  output logic           ULA_busy,
  output logic           ULA_done,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SHR1 = 4'b0101;
  localparam logic [3:0] OP_SHL1 = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_RORN = 4'b1001;
  localparam logic [3:0] OP_ROLN = 4'b1010;
  localparam logic [3:0] OP_ASRN = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_SHRN = 4'b1101;
  localparam logic [3:0] OP_SHLN = 4'b1110;
  localparam logic [3:0] OP_RSV  = 4'b1111;

  // IDLE: waiting. RUN: iterating. DONE: final step + result write; DONE can
  // also accept a new request when the finishing operation was single-cycle.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [TAM-1:0]   a_reg, b_reg;
  logic [3:0]       ctrl_reg;
  logic             multi_reg;     // current op has latency > 1
  logic [SW-1:0]    cnt_reg;       // remaining RUN steps
  logic [2*TAM-1:0] prod_reg;      // {partial high, multiplier/low product}
  logic [TAM-1:0]   sh_reg;        // shift/rotate working value
  logic [TAM-1:0]   out_reg;
  logic [2:0]       flags_reg;
  logic             done_reg;

  function automatic logic is_nshift(input logic [3:0] op);
    case (op)
      OP_RORN, OP_ROLN, OP_ASRN, OP_SHRN, OP_SHLN: is_nshift = 1'b1;
      default:                                     is_nshift = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [SW-1:0] in_n;
  logic          in_single;
  logic [SW-1:0] in_cnt;
  logic          accept;
  logic          step_en;
  logic          fin_en;

  always_comb begin
    in_n      = ULA_B[SW-1:0];
    in_single = 1'b1;
    in_cnt    = '0;
    if (ULA_ctrl == OP_MUL) begin
      in_single = 1'b0;
      in_cnt    = SW'(TAM - 1);
    end else if (is_nshift(ULA_ctrl) && (in_n > SW'(1))) begin
      in_single = 1'b0;
      in_cnt    = in_n - SW'(1);
    end
  end

  assign accept = ULA_start && !ULA_busy;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (accept) state_next = in_single ? S_DONE : S_RUN;
        else        state_next = S_IDLE;
      end
      S_RUN: begin
        // The last step is performed in DONE, so RUN ends one step early.
        if (cnt_reg == SW'(1)) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ULA_busy = 1'b0;
    step_en  = 1'b0;
    fin_en   = 1'b0;
    case (state_reg)
      S_RUN: begin
        ULA_busy = 1'b1;
        step_en  = 1'b1;
      end
      S_DONE: begin
        ULA_busy = multi_reg;
        fin_en   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iteration step (shared by RUN and the final step in DONE)
  // ---------------------------------------------------------------------------
  logic [TAM:0]     hi_sum;
  logic [2*TAM-1:0] prod_step;
  logic [TAM-1:0]   sh_step;
  logic             sh_out;

  // Right-shifting shift-add multiplier: add A into the high half when the
  // current multiplier bit is 1, then shift the whole product right.
  always_comb begin
    hi_sum    = {1'b0, prod_reg[2*TAM-1:TAM]} + (prod_reg[0] ? {1'b0, a_reg} : '0);
    prod_step = {hi_sum, prod_reg[TAM-1:1]};
  end

  always_comb begin
    sh_step = sh_reg;
    sh_out  = 1'b0;
    case (ctrl_reg)
      OP_RORN: begin
        sh_step = {sh_reg[0], sh_reg[TAM-1:1]};
        sh_out  = sh_reg[0];
      end
      OP_ROLN: begin
        sh_step = {sh_reg[TAM-2:0], sh_reg[TAM-1]};
        sh_out  = sh_reg[TAM-1];
      end
      OP_ASRN: begin
        sh_step = {sh_reg[TAM-1], sh_reg[TAM-1:1]};
        sh_out  = sh_reg[0];
      end
      OP_SHRN: begin
        sh_step = {1'b0, sh_reg[TAM-1:1]};
        sh_out  = sh_reg[0];
      end
      OP_SHLN: begin
        sh_step = {sh_reg[TAM-2:0], 1'b0};
        sh_out  = sh_reg[TAM-1];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Final result and flags
  // ---------------------------------------------------------------------------
  logic [TAM:0]   wide;
  logic [TAM-1:0] fin_res;
  logic           fin_carry;
  logic           fin_wr_out;
  logic [2:0]     fin_flags;
  logic           n_zero;

  always_comb begin
    wide       = '0;
    fin_res    = '0;
    fin_carry  = 1'b0;
    fin_wr_out = 1'b1;
    n_zero     = (b_reg[SW-1:0] == '0);
    case (ctrl_reg)
      OP_ADD: begin
        wide      = {1'b0, a_reg} + {1'b0, b_reg};
        fin_res   = wide[TAM-1:0];
        fin_carry = wide[TAM];
      end
      OP_SUB, OP_CMP: begin
        // Bit TAM of the (TAM+1)-bit difference is the borrow (A < B).
        wide       = {1'b0, a_reg} - {1'b0, b_reg};
        fin_res    = wide[TAM-1:0];
        fin_carry  = wide[TAM];
        fin_wr_out = (ctrl_reg != OP_CMP);
      end
      OP_AND:  fin_res = a_reg & b_reg;
      OP_OR:   fin_res = a_reg | b_reg;
      OP_XOR:  fin_res = a_reg ^ b_reg;
      OP_NOT:  fin_res = ~a_reg;
      OP_SHR1: begin
        fin_res   = {1'b0, a_reg[TAM-1:1]};
        fin_carry = a_reg[0];
      end
      OP_SHL1: begin
        fin_res   = {a_reg[TAM-2:0], 1'b0};
        fin_carry = a_reg[TAM-1];
      end
      OP_MUL: begin
        fin_res   = prod_step[TAM-1:0];
        fin_carry = |prod_step[2*TAM-1:TAM];
      end
      OP_RORN, OP_ROLN, OP_ASRN, OP_SHRN, OP_SHLN: begin
        fin_res   = n_zero ? sh_reg : sh_step;
        fin_carry = n_zero ? 1'b0 : sh_out;
      end
      default: ;  // reserved: result 0, flags forced below
    endcase
    if (ctrl_reg == OP_RSV) fin_flags = 3'b000;
    else                    fin_flags = {fin_res[TAM-1], (fin_res == '0), fin_carry};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ctrl_reg  <= '0;
      multi_reg <= 1'b0;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      sh_reg    <= '0;
      out_reg   <= '0;
      flags_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= fin_en;
      if (fin_en) begin
        if (fin_wr_out) out_reg <= fin_res;
        flags_reg <= fin_flags;
      end
      if (step_en) begin
        prod_reg <= prod_step;
        sh_reg   <= sh_step;
        cnt_reg  <= cnt_reg - SW'(1);
      end
      // accept never coincides with step_en (RUN holds busy high)
      if (accept) begin
        a_reg     <= ULA_A;
        b_reg     <= ULA_B;
        ctrl_reg  <= ULA_ctrl;
        multi_reg <= !in_single;
        cnt_reg   <= in_cnt;
        prod_reg  <= {{TAM{1'b0}}, ULA_B};
        sh_reg    <= ULA_A;
      end
    end
  end

  assign ULA_OUT   = out_reg;
  assign ULA_flags = flags_reg;
  assign ULA_done  = done_reg;

endmodule
